mult_seq: RTL

Sequential 32×32 multiplier for the ALU's HI/LO path, the counterpart to the iterative divider for MIPS `mult`/`multu`. It accepts one operand pair per request over the same `validIn`/`validOut` handshake the divider uses. It computes the 64-bit product with a radix-2 shift-add loop, one partial product per cycle, and writes the upper word to `Hi` and the lower word to `Lo`.

---
 rtl/mult_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/mult_seq.sv
// Sequential radix-2 shift-add multiplier for the MIPS mult/multu HI/LO path.
// One partial product per cycle; result registered on the last iteration.
module mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             validIn,
  input  logic             sign,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             validOut,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_acc;
  logic [CntW-1:0]    r_count;
  logic               r_valid;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_acc_sum;
  logic [2*WIDTH-1:0] w_product;
  logic               w_last;

  // Operands are held as magnitudes; 0x80000000 negates to itself, read as unsigned.
  assign w_mag_a   = (sign && SrcA[WIDTH-1]) ? (~SrcA + WIDTH'(1)) : SrcA;
  assign w_mag_b   = (sign && SrcB[WIDTH-1]) ? (~SrcB + WIDTH'(1)) : SrcB;

  assign w_addend  = r_mplier[r_count] ? ({{WIDTH{1'b0}}, r_mcand} << r_count) : '0;
  assign w_acc_sum = r_acc + w_addend;
  assign w_product = r_neg ? (~w_acc_sum + (2*WIDTH)'(1)) : w_acc_sum;
  assign w_last    = (r_count == CntW'(WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (validIn) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (validIn) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_neg    <= sign & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        StRun: begin
          r_acc   <= w_acc_sum;
          r_count <= r_count + CntW'(1);
          if (w_last) begin
            r_hi    <= w_product[2*WIDTH-1:WIDTH];
            r_lo    <= w_product[WIDTH-1:0];
            r_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != StIdle);
  assign validOut = r_valid;
  assign Hi       = r_hi;
  assign Lo       = r_lo;

endmodule
